pc_fetch_ctrl: RTL

//   Fetch-stage PC generator and instruction buffer feeding decode. Holds the PC,

---
 rtl/pc_fetch_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC generator: one outstanding instruction request, a small response
// FIFO toward decode, and redirect handling that discards wrong-path fetches.
module pc_fetch_ctrl #(
  parameter logic [63:0] PC_RESET  = 64'h8000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic [63:0] pc_target,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  input  logic        d_ready
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  // Handshake rules: a request is offered while ireq_valid=1 and completes in the
  // cycle iresp_data_ok=1; address is held until then. Decode takes the head in
  // any cycle where f_valid && d_ready.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     pc_q, pc_d;
  logic [63:0]     stall_q, stall_d;
  logic            drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [63:0]     mem_pc_q    [BUF_DEPTH];
  logic [63:0]     mem_pc_d    [BUF_DEPTH];
  logic [31:0]     mem_instr_q [BUF_DEPTH];
  logic [31:0]     mem_instr_d [BUF_DEPTH];

  logic            pop;
  logic            push;
  logic            flush;
  logic [CW-1:0]   cnt_after_pop;

  assign f_valid    = (count_q != '0) && !drop_q;
  assign f_pc       = mem_pc_q[rd_q];
  assign f_instr    = mem_instr_q[rd_q];
  assign ireq_valid = (state_q != ST_IDLE);
  // While draining a dead request the memory still sees its original address.
  assign ireq_addr  = (state_q == ST_DRAIN) ? stall_q : pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    stall_d       = stall_q;
    drop_d        = drop_q;
    count_d       = count_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    mem_pc_d      = mem_pc_q;
    mem_instr_d   = mem_instr_q;
    push          = 1'b0;
    flush         = 1'b0;
    pop           = f_valid && d_ready;
    cnt_after_pop = count_q - CW'(pop);

    case (state_q)
      ST_IDLE: begin
        if (pc_src) begin
          flush = 1'b1;
          pc_d  = pc_target;
        end else if (cnt_after_pop < CW'(BUF_DEPTH)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (pc_src) begin
          flush = 1'b1;
          pc_d  = pc_target;
          if (iresp_data_ok) begin
            state_d = ST_IDLE;
          end else begin
            stall_d = pc_q;
            drop_d  = 1'b1;
            state_d = ST_DRAIN;
          end
        end else if (iresp_data_ok) begin
          push = 1'b1;
          pc_d = pc_q + 64'd4;
          // Only keep requesting if the pushed entry still leaves a free slot.
          if (cnt_after_pop < CW'(BUF_DEPTH - 1)) state_d = ST_REQ;
          else                                   state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (pc_src) pc_d = pc_target;
        if (iresp_data_ok) begin
          drop_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      if (push) begin
        mem_pc_d[wr_q]    = pc_q;
        mem_instr_d[wr_q] = iresp_data;
        wr_d              = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      count_d = cnt_after_pop + CW'(push);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RESET;
      stall_q <= PC_RESET;
      drop_q  <= 1'b0;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stall_q     <= stall_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
    end
  end

endmodule
